// File: rtl/aes_192_feeder_pkg.sv
// Shared types and sizes for the AES-192 feeder.
// The FSM state encoding and the word counts of the key and state vectors live here.
package aes192_feeder_pkg;

  localparam int WORD_W      = 32;
  localparam int KEY_WORDS   = 6;
  localparam int STATE_WORDS = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_KEY   = 3'd1,
    LOAD_STATE = 3'd2,
    START      = 3'd3,
    WAIT_ACK   = 3'd4,
    WAIT_DONE  = 3'd5,
    RESULT     = 3'd6
  } feeder_state_e;

endpackage

// File: rtl/aes_192_feeder_word_shifter.sv
// Word-serial loader: each loaded word enters at the bottom, so the first word of a
// sequence ends up in the most-significant slot once all words are in.
module aes192_word_shifter
  import aes192_feeder_pkg::*;
#(
  parameter int P_WORD_W  = WORD_W,
  parameter int P_N_WORDS = STATE_WORDS
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_load,
  input  logic                          i_clear,
  input  logic [P_WORD_W-1:0]           i_word,
  output logic [P_WORD_W*P_N_WORDS-1:0] o_vec
);

  logic [P_WORD_W*P_N_WORDS-1:0] r_vec;

  // shift register; clear takes priority over load
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vec <= '0;
    end else if (i_clear) begin
      r_vec <= '0;
    end else if (i_load) begin
      r_vec <= {r_vec[P_WORD_W*(P_N_WORDS-1)-1:0], i_word};
    end else begin
      r_vec <= r_vec;
    end
  end

  assign o_vec = r_vec;

endmodule

// File: rtl/aes_192_feeder.sv
// Sequencer in front of the pipelined AES-192 core: word loading, start edge, watchdog, result port.
// Optional build macro AES192_FEEDER_ZEROISE_EN wipes key, state and result after each job.
module aes_192_feeder
  import aes192_feeder_pkg::*;
#(
  parameter int START_HOLD = 2,
  parameter int TIMEOUT    = 63
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_key_reuse,
  output logic         core_start,
  output logic [127:0] core_state,
  output logic [191:0] core_key,
  input  logic [127:0] core_out,
  input  logic         core_out_valid,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         err_timeout
);

`ifdef AES192_FEEDER_ZEROISE_EN
  localparam logic ZEROISE_EN = 1'b1;
`else
  localparam logic ZEROISE_EN = 1'b0;
`endif

  localparam logic [2:0] C_KEY_LAST   = 3'(KEY_WORDS - 1);
  localparam logic [2:0] C_STATE_LAST = 3'(STATE_WORDS - 1);
  localparam logic [2:0] C_HOLD_LAST  = 3'(START_HOLD - 1);
  localparam logic [7:0] C_WDOG_LAST  = 8'(TIMEOUT - 1);

  feeder_state_e r_state;
  logic [2:0]    r_cnt;
  logic [7:0]    r_wdog;
  logic          r_key_loaded;
  logic          r_in_ready;
  logic          r_core_start;
  logic          r_res_valid;
  logic          r_err_timeout;
  logic [127:0]  r_res_data;

  feeder_state_e w_next_state;
  logic [2:0]    w_next_cnt;
  logic [7:0]    w_next_wdog;
  logic          w_next_key_loaded;
  logic          w_accept;
  logic          w_key_load;
  logic          w_state_load;
  logic          w_res_capture;
  logic          w_timeout;
  logic          w_zeroise;

  assign w_accept = in_valid & r_in_ready;

  // state register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state, counters and datapath strobes
  always_comb begin
    w_next_state      = r_state;
    w_next_cnt        = r_cnt;
    w_next_wdog       = r_wdog;
    w_next_key_loaded = r_key_loaded;
    w_key_load        = 1'b0;
    w_state_load      = 1'b0;
    w_res_capture     = 1'b0;
    w_timeout         = 1'b0;
    w_zeroise         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_cnt = 3'd1;
          if (in_key_reuse && r_key_loaded) begin
            w_state_load = 1'b1;
            w_next_state = LOAD_STATE;
          end else begin
            w_key_load   = 1'b1;
            w_next_state = LOAD_KEY;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      LOAD_KEY: begin
        if (w_accept) begin
          w_key_load = 1'b1;
          if (r_cnt == C_KEY_LAST) begin
            w_next_key_loaded = 1'b1;
            w_next_cnt        = 3'd0;
            w_next_state      = LOAD_STATE;
          end else begin
            w_next_cnt = r_cnt + 3'd1;
          end
        end else begin
          w_next_state = LOAD_KEY;
        end
      end
      LOAD_STATE: begin
        if (w_accept) begin
          w_state_load = 1'b1;
          if (r_cnt == C_STATE_LAST) begin
            w_next_cnt   = 3'd0;
            w_next_wdog  = 8'd0;
            w_next_state = START;
          end else begin
            w_next_cnt = r_cnt + 3'd1;
          end
        end else begin
          w_next_state = LOAD_STATE;
        end
      end
      START, WAIT_ACK, WAIT_DONE: begin
        w_next_wdog = r_wdog + 8'd1;
        // the watchdog overrides whatever the core is doing in this cycle
        if (r_wdog == C_WDOG_LAST) begin
          w_timeout    = 1'b1;
          w_zeroise    = ZEROISE_EN;
          w_next_cnt   = 3'd0;
          w_next_state = IDLE;
        end else begin
          case (r_state)
            START: begin
              if (r_cnt == C_HOLD_LAST) begin
                w_next_cnt   = 3'd0;
                w_next_state = WAIT_ACK;
              end else begin
                w_next_cnt = r_cnt + 3'd1;
              end
            end
            WAIT_ACK: begin
              // a valid still high from the previous job is stale; wait for it to drop
              if (!core_out_valid) begin
                w_next_state = WAIT_DONE;
              end else begin
                w_next_state = WAIT_ACK;
              end
            end
            WAIT_DONE: begin
              if (core_out_valid) begin
                w_res_capture = 1'b1;
                w_next_state  = RESULT;
              end else begin
                w_next_state = WAIT_DONE;
              end
            end
            default: begin
              w_next_state = IDLE;
            end
          endcase
        end
      end
      RESULT: begin
        if (res_ready) begin
          w_zeroise    = ZEROISE_EN;
          w_next_state = IDLE;
        end else begin
          w_next_state = RESULT;
        end
      end
      default: begin
        w_next_cnt   = 3'd0;
        w_next_state = IDLE;
      end
    endcase
    if (w_zeroise) begin
      w_next_key_loaded = 1'b0;
    end else begin
      w_next_key_loaded = w_next_key_loaded;
    end
  end

  // counters, key flag and registered output decodes
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_cnt         <= 3'd0;
      r_wdog        <= 8'd0;
      r_key_loaded  <= 1'b0;
      r_in_ready    <= 1'b0;
      r_core_start  <= 1'b0;
      r_res_valid   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_cnt         <= w_next_cnt;
      r_wdog        <= w_next_wdog;
      r_key_loaded  <= w_next_key_loaded;
      r_in_ready    <= (w_next_state == IDLE) || (w_next_state == LOAD_KEY) ||
                       (w_next_state == LOAD_STATE);
      r_core_start  <= (w_next_state == START);
      r_res_valid   <= (w_next_state == RESULT);
      r_err_timeout <= w_timeout;
    end
  end

  // ciphertext holding register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_res_data <= 128'd0;
    end else if (w_zeroise) begin
      r_res_data <= 128'd0;
    end else if (w_res_capture) begin
      r_res_data <= core_out;
    end else begin
      r_res_data <= r_res_data;
    end
  end

  aes192_word_shifter #(
    .P_WORD_W (WORD_W),
    .P_N_WORDS(KEY_WORDS)
  ) u_key_shifter (
    .i_clk  (clk),
    .i_rst  (rst_i),
    .i_load (w_key_load),
    .i_clear(w_zeroise),
    .i_word (in_data),
    .o_vec  (core_key)
  );

  aes192_word_shifter #(
    .P_WORD_W (WORD_W),
    .P_N_WORDS(STATE_WORDS)
  ) u_state_shifter (
    .i_clk  (clk),
    .i_rst  (rst_i),
    .i_load (w_state_load),
    .i_clear(w_zeroise),
    .i_word (in_data),
    .o_vec  (core_state)
  );

  assign in_ready    = r_in_ready;
  assign core_start  = r_core_start;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_aes_192_feeder.sv
// Directed bench for aes_192_feeder with a behavioural AES core stand-in and a per-cycle output checker.
module tb_aes_192_feeder;

  localparam logic [191:0] FIPS_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [191:0] KEY2     = 192'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7;
  localparam logic [127:0] NEW_PT   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] TO_PT    = 128'hcafef00d11223344deadbeef55667788;
  localparam logic [127:0] R_PT     = 128'h13579bdf2468ace0fdb975310eca8642;
  localparam logic [127:0] PT2      = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam int HOLD = 2;
  localparam int TMO  = 63;
  localparam int CORE_LAT = 26;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_key_reuse;
  logic         core_start;
  logic [127:0] core_state;
  logic [191:0] core_key;
  logic [127:0] core_out;
  logic         core_out_valid;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         err_timeout;

  int total = 0;
  int bad   = 0;

  logic [191:0] exp_key;
  logic [127:0] exp_state;
  bit           never_mode;
  int           ack_delay;

  aes_192_feeder dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_key_reuse  (in_key_reuse),
    .core_start    (core_start),
    .core_state    (core_state),
    .core_key      (core_key),
    .core_out      (core_out),
    .core_out_valid(core_out_valid),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // stand-in for the AES core: the FIPS-197 vector, otherwise a simple keyed mix
  function automatic logic [127:0] core_fn(input logic [191:0] k, input logic [127:0] s);
    if (k == FIPS_KEY && s == FIPS_PT) return FIPS_CT;
    else return s ^ k[191:64] ^ {k[63:0], k[63:0]};
  endfunction

  function automatic logic [31:0] word_of(input logic [191:0] k, input logic [127:0] s,
                                          input bit with_key, input int idx);
    int j;
    j = with_key ? idx - 6 : idx;
    if (with_key && idx < 6) return k[191 - 32*idx -: 32];
    else return s[127 - 32*j -: 32];
  endfunction

  function automatic logic sel(input int which);
    case (which)
      0: return core_start;
      1: return res_valid;
      2: return err_timeout;
      default: return 1'b0;
    endcase
  endfunction

  // core model: latches key/state on the start edge, drops out_valid after ack_delay,
  // raises it with the result CORE_LAT cycles after the edge and holds it until the next edge
  int cm_lat, cm_ack;
  bit cm_busy, cm_prev;
  logic [191:0] cm_key;
  logic [127:0] cm_state;
  always @(negedge clk) begin
    if (rst_i) begin
      core_out_valid = 1'b0;
      core_out = '0;
      cm_busy = 0; cm_ack = 0; cm_prev = 0; cm_lat = 0;
    end else begin
      if (core_start && !cm_prev) begin
        cm_lat = CORE_LAT; cm_busy = 1; cm_ack = ack_delay;
        cm_key = core_key; cm_state = core_state;
      end else begin
        if (cm_ack > 0) begin
          cm_ack--;
          if (cm_ack == 0) core_out_valid = 1'b0;
        end
        if (cm_busy) begin
          cm_lat--;
          if (cm_lat == 0) begin
            cm_busy = 0;
            if (!never_mode) begin
              core_out = core_fn(cm_key, cm_state);
              core_out_valid = 1'b1;
            end
          end
        end
      end
      cm_prev = core_start;
    end
  end

  // per-cycle checker against the job the bench believes is in flight
  bit ck_prev_cs;
  int run_len, since_edge;
  always @(negedge clk) begin
    if (rst_i) begin
      ck_prev_cs = 0; run_len = 0; since_edge = 1000;
    end else begin
      if (core_start && !ck_prev_cs) since_edge = 0;
      else if (since_edge < 1000) since_edge++;
      if (core_start) begin
        run_len++;
        check("start_key", core_key, exp_key);
        check("start_state", 192'(core_state), 192'(exp_state));
        check("ready_in_start", 192'(in_ready), 192'(0));
      end else if (ck_prev_cs) begin
        check("start_len", 192'(run_len), 192'(HOLD));
        run_len = 0;
      end
      check("err_timing", 192'(err_timeout), 192'(never_mode && since_edge == TMO));
      check("no_res_on_timeout_job", 192'(res_valid && never_mode), 192'(0));
      if (res_valid) begin
        check("res_data", 192'(res_data), 192'(core_fn(exp_key, exp_state)));
        check("ready_in_result", 192'(in_ready), 192'(0));
      end
      ck_prev_cs = core_start;
    end
  end

  task automatic send(input logic [31:0] d, input bit reuse);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_key_reuse = reuse;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_ready", 192'(in_ready), 192'(1));
    @(negedge clk);
    in_valid = 1'b0; in_key_reuse = 1'b0;
  endtask

  task automatic wait_for(input int which, input string name, input int budget);
    int n;
    n = 0;
    while (sel(which) == 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 192'(sel(which)), 192'(1));
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_dropped", 192'(res_valid), 192'(0));
  endtask

  initial begin
    int n;
    rst_i = 1'b1; in_valid = 1'b0; in_data = '0; in_key_reuse = 1'b0; res_ready = 1'b0;
    never_mode = 0; ack_delay = 1; exp_key = FIPS_KEY; exp_state = FIPS_PT;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 192'(in_ready), 192'(0));
    check("rst_core_start", 192'(core_start), 192'(0));
    check("rst_res_valid", 192'(res_valid), 192'(0));
    check("rst_err", 192'(err_timeout), 192'(0));
    check("rst_core_key", core_key, 192'(0));
    check("rst_core_state", 192'(core_state), 192'(0));
    check("rst_res_data", 192'(res_data), 192'(0));
    rst_i = 1'b0;
    @(negedge clk);

    // FIPS-197 job with a full key
    for (int i = 0; i < 10; i++) send(word_of(FIPS_KEY, FIPS_PT, 1, i), 1'b0);
    wait_for(0, "job1_start", 3);
    check("job1_key", core_key, 192'h000102030405060708090a0b0c0d0e0f1011121314151617);
    check("job1_state", 192'(core_state), 192'(128'h00112233445566778899aabbccddeeff));
    wait_for(1, "job1_result", 60);
    check("job1_ct", 192'(res_data), 192'(128'hdda97ca4864cdfe06eaf70a0ec0d7191));

    // backpressure with the next job's first word already waiting
    in_valid = 1'b1; in_data = word_of(FIPS_KEY, NEW_PT, 0, 0); in_key_reuse = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", 192'(res_valid), 192'(1));
      check("bp_data", 192'(res_data), 192'(FIPS_CT));
      check("bp_in_ready", 192'(in_ready), 192'(0));
      @(negedge clk);
    end
    ack_delay = 5;
    handshake();
    exp_state = NEW_PT;
    check("idle_after_hs", 192'(in_ready), 192'(1));

    // key reuse: only four state words, stale out_valid still high at the start edge
    for (int i = 0; i < 4; i++) send(word_of(FIPS_KEY, NEW_PT, 0, i), i == 0);
    wait_for(0, "reuse_start", 3);
    check("reuse_key", core_key, FIPS_KEY);
    wait_for(1, "reuse_result", 80);
    check("reuse_ct", 192'(res_data), 192'(core_fn(FIPS_KEY, NEW_PT)));
    handshake();

    // core never answers: watchdog
    never_mode = 1; ack_delay = 1; exp_state = TO_PT;
    for (int i = 0; i < 4; i++) send(word_of(FIPS_KEY, TO_PT, 0, i), i == 0);
    wait_for(0, "to_start", 3);
    n = 0;
    while (!err_timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 192'(n), 192'(TMO));
    check("idle_after_timeout", 192'(in_ready), 192'(1));
    @(negedge clk);
    check("err_one_shot", 192'(err_timeout), 192'(0));
    never_mode = 0;

    // reset while waiting for the core
    exp_state = R_PT;
    for (int i = 0; i < 4; i++) send(word_of(FIPS_KEY, R_PT, 0, i), i == 0);
    wait_for(0, "rj_start", 3);
    repeat (10) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("arst_core_key", core_key, 192'(0));
    check("arst_core_state", 192'(core_state), 192'(0));
    check("arst_res_data", 192'(res_data), 192'(0));
    check("arst_in_ready", 192'(in_ready), 192'(0));
    check("arst_core_start", 192'(core_start), 192'(0));
    check("arst_res_valid", 192'(res_valid), 192'(0));
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // in_key_reuse after reset must still load a full key
    exp_key = KEY2; exp_state = PT2;
    for (int i = 0; i < 9; i++) send(word_of(KEY2, PT2, 1, i), i == 0);
    for (int i = 0; i < 5; i++) begin
      check("nine_no_start", 192'(core_start), 192'(0));
      check("nine_ready", 192'(in_ready), 192'(1));
      @(negedge clk);
    end
    send(word_of(KEY2, PT2, 1, 9), 1'b0);
    wait_for(0, "k2_start", 3);
    check("k2_key", core_key, KEY2);
    wait_for(1, "k2_result", 80);
    check("k2_ct", 192'(res_data), 192'(core_fn(KEY2, PT2)));
    handshake();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_192_feeder.md
Name: aes_192_feeder

Overview:
- Upstream sequencer for the pipelined AES-192 core.
- Accepts key and plaintext as 32-bit words over a valid/ready stream, then assembles the 192-bit key and 128-bit state.
- Generates a clean rising edge on the core's start input and waits for the core's out_valid.
- Captures the ciphertext and presents it on a valid/ready result port. Flags a watchdog timeout.

Parameters:
- START_HOLD, 2: cycles core_start is held high; legal range 1..7.
- TIMEOUT, 63: maximum cycles from the start edge to out_valid before an error; legal range 32..255.

Ports:
- clk  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  feeder accepts a word
- in_data  in  32  key or state word
- in_key_reuse  in  1  sampled only with the first word of a job; 1 = skip key words and reuse the stored key
- core_start  out  1  to core start
- core_state  out  128  to core state
- core_key  out  192  to core key
- core_out  in  128  from core out
- core_out_valid  in  1  from core out_valid
- res_valid  out  1  ciphertext valid
- res_ready  in  1  consumer accepts
- res_data  out  128  ciphertext
- err_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE
  - in_ready=0, core_start=0, res_valid=0, err_timeout=0
  - core_state, core_key, res_data = 0
  - key_loaded=0, word counter=0, watchdog=0
- Word order is most-significant first:
  - Key words fill core_key[191:160] down to [31:0].
  - State words fill core_state[127:96] down to [31:0].
- FSM states and transitions:
  - IDLE: in_ready=1. The first handshake selects the path:
    - in_key_reuse=1 and key_loaded=1: word stored as state word 0, go to LOAD_STATE with cnt=1.
    - Otherwise: word stored as key word 0, go to LOAD_KEY with cnt=1. in_key_reuse is ignored when key_loaded=0.
  - LOAD_KEY: in_ready=1. Accept key words 1..5. On word 5: key_loaded<=1, cnt<=0, go to LOAD_STATE.
  - LOAD_STATE: in_ready=1. Accept state words until 4 are held, then go to START.
  - START: in_ready=0, core_start=1 for START_HOLD cycles. Watchdog clears on entry. Then go to WAIT_ACK.
    - core_start is 0 in every other state, so each job presents a fresh 0→1 edge.
  - WAIT_ACK: wait for core_out_valid=0, which confirms the core registered the edge; then go to WAIT_DONE.
  - WAIT_DONE: on core_out_valid=1, res_data<=core_out, go to RESULT.
  - RESULT: res_valid=1 until res_valid&res_ready, then go to IDLE. res_data stays stable while res_valid is high.
- Watchdog (8-bit):
  - Counts every cycle in START, WAIT_ACK and WAIT_DONE.
  - On reaching TIMEOUT: err_timeout=1 for one cycle, go to IDLE, no result produced. key_loaded is unchanged.
  - Nominal core latency is about 26 cycles, well under the default.
- in_ready is a registered state decode. No word is accepted in START, WAIT_*, or RESULT.
- in_valid with in_ready=0: the word is held by the source and not consumed.
- If core_out_valid is already 1 on entering WAIT_ACK, the feeder keeps waiting for it to drop. A stale result is never captured.
- Reset mid-job: all progress is discarded and the stored key is invalidated (key_loaded=0).

Optional Feature:
- Macro: AES192_FEEDER_ZEROISE_EN
- Defined:
  - On the res handshake and on timeout, core_state and res_data clear to 0 on the next cycle.
  - core_key also clears to 0 and key_loaded<=0, so key reuse is effectively disabled.
- Undefined:
  - Registers keep their last values.
  - Key reuse works as specified above.

Decomposition:
- Package aes192_feeder_pkg holds:
  - FSM state enum (IDLE, LOAD_KEY, LOAD_STATE, START, WAIT_ACK, WAIT_DONE, RESULT)
  - KEY_WORDS=6, STATE_WORDS=4, WORD_W=32
- Sub-module aes192_word_shifter: generic word-in/vector-out shift register with load enable and clear. One instance for the key, one for the state.
- FSM and watchdog stay in the top module.

Test Plan:
- Full FIPS-197 AES-192 job, bench core model with 26-cycle latency:
  - Stimulus: key words 00010203, 04050607 … 14151617; state words 00112233 … ccddeeff.
  - Required: core_key=0x000102…1617, core_state=0x00112233…eeff, core_start high exactly 2 cycles, res_data=0xdda97ca4864cdfe06eaf70a0ec0d7191 captured.
- Key reuse: after the job above, start a new job with in_key_reuse=1 and 4 state words.
  - Required: no key words consumed, core_key unchanged, result produced.
- in_key_reuse=1 directly after reset:
  - Required: the first word is loaded as key word 0 and 10 words are required.
- Backpressure: hold res_ready=0 for 20 cycles.
  - Required: res_valid and res_data stable, in_ready=0 throughout; next job accepted only after the handshake.
- Core model never raises out_valid:
  - Required: err_timeout pulses once, 63 cycles after the start edge; FSM returns to IDLE; res_valid never asserts.
- Assert rst_i during WAIT_DONE:
  - Required: all outputs go to 0 immediately (async); a subsequent in_key_reuse=1 job requires a full key.
